// File: rtl/jt89_pkg.sv
// jt89_pkg: shared definitions for the jt89 host-side write sequencer.
//   - PSG register codes {ch[1:0], type}
//   - sequencer state type
//   - reset values for the volume shadows (and the PSG's ctrl reset value)
package jt89_pkg;

  localparam logic [2:0] REG_TONE0 = 3'b000;
  localparam logic [2:0] REG_VOL0  = 3'b001;
  localparam logic [2:0] REG_TONE1 = 3'b010;
  localparam logic [2:0] REG_VOL1  = 3'b011;
  localparam logic [2:0] REG_TONE2 = 3'b100;
  localparam logic [2:0] REG_VOL2  = 3'b101;
  localparam logic [2:0] REG_CTRL3 = 3'b110;
  localparam logic [2:0] REG_VOL3  = 3'b111;

  localparam logic [3:0] VOL_RST  = 4'hF;
  localparam logic [2:0] CTRL_RST = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STRB = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/jt89_wrseq_strobe.sv
// jt89_wrseq_strobe: emits one PSG byte per start pulse.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : load byte_in and begin a strobe (honoured in IDLE, or in the
//                last HOLD cycle so a second byte follows without a gap)
//   byte_in    : byte to place on the bus
//   din, wr_n  : PSG bus; din changes when STRB is entered, wr_n follows the
//                state one cycle later so din is set up before the strobe
//   idle       : state machine is in IDLE
//   done       : last HOLD cycle of the current byte
module jt89_wrseq_strobe
  import jt89_pkg::*;
#(
  parameter int WR_LEN = 2,
  parameter int GAP    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic [7:0] din,
  output logic       wr_n,
  output logic       idle,
  output logic       done
);

  localparam int MAXC  = (WR_LEN > GAP) ? WR_LEN : GAP;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC + 1) : 1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      din   <= 8'h00;
      wr_n  <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load) din <= byte_in;
      // one-cycle lag behind the state gives din a setup cycle
      wr_n  <= (state != ST_STRB);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_STRB;
          cnt_nxt   = CNT_W'(WR_LEN - 1);
          load      = 1'b1;
        end
      end
      ST_STRB: begin
        if (cnt == '0) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = CNT_W'(GAP - 1);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          done = 1'b1;
          if (start) begin
            state_nxt = ST_STRB;
            cnt_nxt   = CNT_W'(WR_LEN - 1);
            load      = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign idle = (state == ST_IDLE);

endmodule

// File: rtl/jt89_wrseq.sv
// jt89_wrseq: host-side write sequencer for the jt89 PSG bus.
// Turns a {register, 10-bit value} request into a latch byte and an optional
// data byte on din/wr_n.
//   clk, rst   : clock, asynchronous active-high reset
//   req_valid  : request present
//   req_ready  : idle, request accepted on req_valid && req_ready
//   req_reg    : register code {ch[1:0], type}
//   req_val    : value (tone [9:0], volume [3:0], ctrl [2:0])
//   din, wr_n  : PSG data bus and active-low write strobe
//   busy       : !req_ready
// Build option: JT89_WRSEQ_DEDUP_EN enables shadow registers that drop
// redundant bytes or whole requests.
module jt89_wrseq
  import jt89_pkg::*;
#(
  parameter int WR_LEN = 2,
  parameter int GAP    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_reg,
  input  logic [9:0] req_val,
  output logic [7:0] din,
  output logic       wr_n,
  output logic       busy
);

  logic       accept;
  logic       idle, done, start;
  logic [7:0] latch_byte, data_byte, start_byte;
  logic       send_latch, send_data;
  logic       is_tone, is_vol;
  logic [7:0] byte2;
  logic       pend;

  assign accept     = req_valid && req_ready;
  assign latch_byte = {1'b1, req_reg, req_val[3:0]};
  assign data_byte  = {2'b00, req_val[9:4]};
  assign is_vol     = req_reg[0];
  assign is_tone    = !req_reg[0] && (req_reg != REG_CTRL3);

`ifdef JT89_WRSEQ_DEDUP_EN
  logic [9:0] tone_sh [4];
  logic [3:0] vol_sh  [4];
  logic [2:0] last_reg;
  logic       last_reg_vld;
  logic       lo_chg, hi_chg;

  assign lo_chg = req_val[3:0] != tone_sh[req_reg[2:1]][3:0];
  assign hi_chg = req_val[9:4] != tone_sh[req_reg[2:1]][9:4];

  always_comb begin
    send_latch = 1'b1;
    send_data  = 1'b0;
    if (is_tone) begin
      // a data byte alone lands in whatever register the PSG last latched,
      // so it is only safe when that register is this tone
      send_data  = hi_chg;
      send_latch = lo_chg || (hi_chg && !(last_reg_vld && last_reg == req_reg));
    end else if (is_vol) begin
      send_latch = req_val[3:0] != vol_sh[req_reg[2:1]];
    end
    // noise ctrl always writes: every write restarts the noise LFSR
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        tone_sh[i] <= 10'd0;
        vol_sh[i]  <= VOL_RST;
      end
      last_reg     <= REG_TONE0;
      last_reg_vld <= 1'b0;
    end else if (accept) begin
      if (is_tone) tone_sh[req_reg[2:1]] <= req_val;
      if (is_vol)  vol_sh[req_reg[2:1]]  <= req_val[3:0];
      if (send_latch) begin
        last_reg     <= req_reg;
        last_reg_vld <= 1'b1;
      end
    end
  end
`else
  always_comb begin
    send_latch = 1'b1;
    send_data  = is_tone;
  end
`endif

  // first byte goes straight to the strobe unit; the data byte of a
  // two-byte request waits here until the latch byte's HOLD finishes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0;
    end else if (accept) begin
      pend <= send_latch && send_data;
    end else if (done) begin
      pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) byte2 <= data_byte;
  end

  assign start      = (accept && (send_latch || send_data)) || (done && pend);
  assign start_byte = accept ? (send_latch ? latch_byte : data_byte) : byte2;

  jt89_wrseq_strobe #(
    .WR_LEN (WR_LEN),
    .GAP    (GAP)
  ) u_strobe (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .byte_in (start_byte),
    .din     (din),
    .wr_n    (wr_n),
    .idle    (idle),
    .done    (done)
  );

  assign req_ready = idle;
  assign busy      = !idle;

endmodule

// File: doc/jt89_wrseq.md
# jt89_wrseq

Host-side write sequencer for the jt89 PSG bus. It converts word-level register requests (register code plus up to 10-bit value) into the byte stream the PSG expects on `din`/`wr_n`: latch byte, then an optional data byte. Strobe width and inter-byte gap are programmable, and each request completes through a valid/ready handshake. It sits between a CPU or sound-driver FSM and a jt89 instance.

## Interface

**Parameters**

- `WR_LEN`, default 2: `wr_n` low time per byte, in `clk` cycles (≥1).
- `GAP`, default 2: `wr_n` high time after each byte, in `clk` cycles (≥1).

**Ports**

- `clk` in 1: system clock, the same clock that feeds jt89.
- `rst` in 1: reset. Asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: sequencer idle and able to accept.
- `req_reg` in 3: register code {ch[1:0], type}. 000/010/100 are tone0–2, 110 is noise ctrl, xx1 is volume.
- `req_val` in 10: value. Tone uses [9:0], volume uses [3:0], ctrl uses [2:0]; unused bits are ignored.
- `din` out 8: PSG data bus.
- `wr_n` out 1: PSG write strobe, active-low.
- `busy` out 1: equal to `!req_ready`.

## Operation

- Handshake: a request is accepted on a `clk` edge with `req_valid && req_ready`. `req_ready` is high only in IDLE.
- Latch byte is `{1, req_reg, val[3:0]}`. Data byte is `{2'b00, val[9:4]}`.
- Without dedup:
  - Tone requests send latch + data.
  - Volume requests send latch only.
  - Ctrl requests send latch only.
- FSM states:
  - IDLE → STRB on accept if the byte count is > 0; otherwise stay in IDLE.
  - STRB: `wr_n` = 0 for `WR_LEN` cycles → HOLD.
  - HOLD: `wr_n` = 1 for `GAP` cycles. Then go to STRB if a second byte is pending, else to IDLE.
- `din` is loaded on entry to STRB and held stable through the end of that byte's HOLD.
- `din` keeps its last value while in IDLE.
- Request fields are captured at accept. Input changes during a sequence have no effect.
- A `last_reg` register tracks the PSG's latched register: it is updated with `req_reg` on every latch byte sent.
- Volume values are written as given. 0 is loudest and F is off.

## Timing

- Reset values:
  - `wr_n` = 1, `din` = 8'h00, `req_ready` = 1, `busy` = 0, state IDLE.
  - Shadows: tones = 0, volumes = 4'hF, ctrl = 3'b100.
  - `last_reg_vld` = 0.
- Reset asserted mid-strobe forces `wr_n` high immediately (asynchronously). The partial byte is abandoned.
- Accept at edge N → `wr_n` falls at edge N+1.
- A 1-byte request is busy for `WR_LEN`+`GAP` cycles. A 2-byte request is busy for 2×(`WR_LEN`+`GAP`).
- `req_ready` rises on the edge that ends the final HOLD. Back-to-back requests therefore always keep ≥ `GAP` high cycles between strobes.
- A skipped request (dedup, zero bytes) is accepted, and `req_ready` stays high: 0-cycle busy, no strobe.

## Configuration

`JT89_WRSEQ_DEDUP_EN` enables shadow-register write elimination.

**Defined:** shadows hold the last value sent for each register.

- Tone, only [3:0] changed → latch byte only.
- Tone, only [9:4] changed, with `last_reg_vld && last_reg == req_reg` → data byte only.
- Tone, [9:4] changed but `last_reg` differs → latch + data.
- Tone, both fields changed → latch + data.
- Tone or volume unchanged → skip.
- Noise ctrl is never skipped, because each write clears the noise LFSR.

**Undefined:** no shadows and no skip logic. Byte counts are fixed as listed under Operation.

## Structure

- Package `jt89_pkg`:
  - Register-code localparams (`REG_TONE0` … `REG_VOL3`, `REG_CTRL3`).
  - FSM state typedef.
  - Reset constants for volume (4'hF) and ctrl (3'b100).
- Sub-module `jt89_wrseq_strobe`:
  - Takes a byte and a start pulse.
  - Produces `din`/`wr_n`, times `WR_LEN`/`GAP`, and returns `done`.
- The top level holds the handshake, byte-plan logic, shadows and `last_reg`.

## Test plan

- **Volume write.** After reset, request reg=001, val=4'h3 → one strobe with `din`=8'h93, `wr_n` low for 2 cycles then high for 2, `req_ready` back after 4 cycles.
- **Tone write.** Request reg=010, val=10'h2A5 → bytes 8'hA5 then 8'h2A. Falling edges are 4 cycles apart; busy lasts 8 cycles.
- **Dedup, data only** (macro defined). Tone1 10'h2A5, then tone1 10'h3A5 → second request sends only 8'h3A. Then tone1 10'h3A5 again → skipped, no strobe, ready stays high.
- **Dedup, latch restored** (macro defined). Tone0 10'h010, vol0 4'h0, tone0 10'h020 → last request sends 8'h80 then 8'h02, because `last_reg` ≠ tone0.
- **Ctrl never skipped.** Two identical ctrl writes of val 3'b100 → two strobes, each `din`=8'hE4.
- **Reset mid-operation.** Assert `rst` during the first STRB of a tone write → `wr_n`=1 without waiting for a clock edge. After release: IDLE, `req_ready`=1, and the next request emits a full latch + data pair.
